elevator_sched: RTL and testbench

- Floor-request scheduler and motion sequencer for the elevator car.
- Latches hall/cab requests, picks the next target with SCAN (keep direction while requests remain ahead), and times floor travel and door dwell.
- Uses a single-cycle tick enable from an internal prescaler instead of a derived clock, so all logic stays on the board clock domain.
- Outputs drive the floor display, motor direction and door actuator logic.

---
 rtl/elevator_pkg.sv | 24 ++
 rtl/elevator_sched_tick_gen.sv | 36 +++
 rtl/elevator_sched.sv | 201 ++++++++++++++++++++
 tb/tb_elevator_sched.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator scheduler slice.
//   state_e       : car sequencer states
//   floor_w()     : width of a floor index for a given floor count
//   TICK_DIV_7HZ  : board clocks per 7 Hz tick at 50 MHz
//   DEFAULT_*     : default travel and door-dwell lengths in ticks
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR_OPEN = 2'd3
  } state_e;

  localparam int TICK_DIV_7HZ         = 7142857;
  localparam int DEFAULT_TRAVEL_TICKS = 2;
  localparam int DEFAULT_DOOR_TICKS   = 3;

  // A single-floor building still needs a 1-bit floor port.
  function automatic int floor_w(input int num_floors);
    return (num_floors > 1) ? $clog2(num_floors) : 1;
  endfunction

endpackage

// File: rtl/elevator_sched_tick_gen.sv
// Free-running prescaler producing a one-cycle enable pulse.
//   clk    : board clock
//   rst    : synchronous active-high reset, restarts the count at 0
//   tick_o : high for exactly one cycle every TICK_DIV cycles (count == TICK_DIV-1)
module tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick_o
);

  localparam int              CNT_W    = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = (count_q == CNT_LAST) ? '0 : count_q + 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of the order blocks are evaluated.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Decoded from the count, so it is already low in reset (TICK_DIV >= 2).
  assign tick_o = (count_q == CNT_LAST);

endmodule

// File: rtl/elevator_sched.sv
// SCAN floor scheduler and motion sequencer for one elevator car.
//   clk         : board clock
//   rst         : synchronous active-high reset
//   req_i       : hall/cab request bits, one per floor (level or pulse)
//   floor_o     : current car floor
//   dir_up_o    : 1 = travelling up or last travelled up, 0 = down
//   moving_o    : car is travelling between floors
//   door_open_o : door is held open at the current floor
//   pending_o   : latched requests not yet served
//   tick_o      : prescaler enable pulse (debug / display blink)
module elevator_sched
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS   = 4,
  parameter int TICK_DIV     = TICK_DIV_7HZ,
  parameter int TRAVEL_TICKS = DEFAULT_TRAVEL_TICKS,
  parameter int DOOR_TICKS   = DEFAULT_DOOR_TICKS
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_FLOORS-1:0]            req_i,
  output logic [floor_w(NUM_FLOORS)-1:0]   floor_o,
  output logic                             dir_up_o,
  output logic                             moving_o,
  output logic                             door_open_o,
  output logic [NUM_FLOORS-1:0]            pending_o,
  output logic                             tick_o
);

  localparam int FLOOR_W  = floor_w(NUM_FLOORS);
  localparam int TRAVEL_W = $clog2(TRAVEL_TICKS + 1);
  localparam int DWELL_W  = $clog2(DOOR_TICKS + 1);
  localparam logic [TRAVEL_W-1:0] TRAVEL_LAST = TRAVEL_W'(TRAVEL_TICKS);
  localparam logic [DWELL_W-1:0]  DWELL_LAST  = DWELL_W'(DOOR_TICKS);

  state_e                state_q,   state_d;
  logic [FLOOR_W-1:0]    floor_q,   floor_d;
  logic                  dir_up_q,  dir_up_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic [TRAVEL_W-1:0]   travel_q,  travel_d;
  logic [DWELL_W-1:0]    dwell_q,   dwell_d;

  logic                  tick;
  logic [NUM_FLOORS-1:0] clear_vec;
  logic [FLOOR_W-1:0]    floor_up;
  logic [FLOOR_W-1:0]    floor_dn;
  logic [TRAVEL_W-1:0]   travel_inc;
  logic [DWELL_W-1:0]    dwell_inc;
  logic                  above;
  logic                  below;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .tick_o (tick)
  );

  function automatic logic any_above(input logic [NUM_FLOORS-1:0] p,
                                     input logic [FLOOR_W-1:0]    f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (p[i] && (FLOOR_W'(i) > f)) r = 1'b1;
    end
    return r;
  endfunction

  function automatic logic any_below(input logic [NUM_FLOORS-1:0] p,
                                     input logic [FLOOR_W-1:0]    f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (p[i] && (FLOOR_W'(i) < f)) r = 1'b1;
    end
    return r;
  endfunction

  assign floor_up   = floor_q + 1'b1;
  assign floor_dn   = floor_q - 1'b1;
  assign travel_inc = travel_q + 1'b1;
  assign dwell_inc  = dwell_q + 1'b1;
  assign above      = any_above(pending_q, floor_q);
  assign below      = any_below(pending_q, floor_q);

  // NOTE: every signal written here gets a default first, so no path through
  // the case/if tree can leave it unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    floor_d   = floor_q;
    dir_up_d  = dir_up_q;
    travel_d  = travel_q;
    dwell_d   = dwell_q;
    clear_vec = '0;

    case (state_q)
      IDLE: begin
        // SCAN: keep the last direction while anything lies ahead of it.
        if (pending_q[floor_q]) begin
          state_d = DOOR_OPEN;
          dwell_d = '0;
        end else if (dir_up_q && above) begin
          state_d = MOVE_UP;
        end else if (!dir_up_q && below) begin
          state_d = MOVE_DOWN;
        end else if (above) begin
          state_d  = MOVE_UP;
          dir_up_d = 1'b1;
        end else if (below) begin
          state_d  = MOVE_DOWN;
          dir_up_d = 1'b0;
        end
      end

      MOVE_UP: begin
        if (tick) begin
          if (travel_inc == TRAVEL_LAST) begin
            travel_d = '0;
            floor_d  = floor_up;
            // Arrival is judged against the floor just reached.
            if (pending_q[floor_up]) begin
              state_d = DOOR_OPEN;
              dwell_d = '0;
            end else if (!any_above(pending_q, floor_up)) begin
              state_d = IDLE;
            end
          end else begin
            travel_d = travel_inc;
          end
        end
      end

      MOVE_DOWN: begin
        if (tick) begin
          if (travel_inc == TRAVEL_LAST) begin
            travel_d = '0;
            floor_d  = floor_dn;
            if (pending_q[floor_dn]) begin
              state_d = DOOR_OPEN;
              dwell_d = '0;
            end else if (!any_below(pending_q, floor_dn)) begin
              state_d = IDLE;
            end
          end else begin
            travel_d = travel_inc;
          end
        end
      end

      DOOR_OPEN: begin
        // A fresh press at this floor holds the door for a full dwell again.
        if (req_i[floor_q]) begin
          dwell_d = '0;
        end else if (tick) begin
          if (dwell_inc == DWELL_LAST) begin
            dwell_d = '0;
            state_d = IDLE;
          end else begin
            dwell_d = dwell_inc;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // The served floor is cleared on the entry cycle and throughout the
    // dwell; clearing after the OR lets a clear beat a simultaneous request.
    if ((state_q == DOOR_OPEN) || (state_d == DOOR_OPEN)) begin
      clear_vec[floor_d] = 1'b1;
    end
    pending_d = (pending_q | req_i) & ~clear_vec;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      floor_q   <= '0;
      dir_up_q  <= 1'b1;
      pending_q <= '0;
      travel_q  <= '0;
      dwell_q   <= '0;
    end else begin
      state_q   <= state_d;
      floor_q   <= floor_d;
      dir_up_q  <= dir_up_d;
      pending_q <= pending_d;
      travel_q  <= travel_d;
      dwell_q   <= dwell_d;
    end
  end

  assign floor_o     = floor_q;
  assign dir_up_o    = dir_up_q;
  assign moving_o    = (state_q == MOVE_UP) || (state_q == MOVE_DOWN);
  assign door_open_o = (state_q == DOOR_OPEN);
  assign pending_o   = pending_q;
  assign tick_o      = tick;

endmodule

// File: tb/tb_elevator_sched.sv
// Directed bench for elevator_sched with TICK_DIV=4, TRAVEL_TICKS=2,
// DOOR_TICKS=3. Inputs change and outputs are sampled on the falling edge.
// "cyc" counts rising edges since reset release; prescaler ticks are
// consumed on the edges where cyc is a multiple of 4.
module tb_elevator_sched;

  logic       clk;
  logic       rst;
  logic [3:0] req_i;
  logic [1:0] floor_o;
  logic       dir_up_o;
  logic       moving_o;
  logic       door_open_o;
  logic [3:0] pending_o;
  logic       tick_o;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  elevator_sched #(
    .NUM_FLOORS   (4),
    .TICK_DIV     (4),
    .TRAVEL_TICKS (2),
    .DOOR_TICKS   (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_i),
    .floor_o     (floor_o),
    .dir_up_o    (dir_up_o),
    .moving_o    (moving_o),
    .door_open_o (door_open_o),
    .pending_o   (pending_o),
    .tick_o      (tick_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Car never leaves the shaft and never moves with the door open.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      checks++;
      if ((floor_o > 2'd3) || (moving_o && door_open_o) || $isunknown(floor_o)) begin
        failures++;
        $display("FAIL monitor: floor_o=%0d moving_o=%b door_open_o=%b (want floor<=3, not both)",
                 floor_o, moving_o, door_open_o);
      end
    end
  end

  task automatic adv(input int n);
    repeat (n) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic goto_cyc(input int t);
    while (cyc < t) adv(1);
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    req_i = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({floor_o, dir_up_o, moving_o, door_open_o, pending_o, tick_o} !== {2'd0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0}) begin
      failures++;
      $display("FAIL reset_values: floor=%0d dir=%b mov=%b door=%b pend=%b tick=%b want 0 1 0 0 0000 0",
               floor_o, dir_up_o, moving_o, door_open_o, pending_o, tick_o);
    end
    goto_cyc(2);
    checks++;
    if (tick_o !== 1'b0) begin
      failures++;
      $display("FAIL tick_early: tick_o=%b want 0 at cyc 2", tick_o);
    end
    goto_cyc(3);
    checks++;
    if (tick_o !== 1'b1) begin
      failures++;
      $display("FAIL tick_first: tick_o=%b want 1 at cyc 3", tick_o);
    end
    goto_cyc(4);
    checks++;
    if (tick_o !== 1'b0) begin
      failures++;
      $display("FAIL tick_single: tick_o=%b want 0 at cyc 4", tick_o);
    end
    goto_cyc(7);
    checks++;
    if (tick_o !== 1'b1) begin
      failures++;
      $display("FAIL tick_period: tick_o=%b want 1 at cyc 7", tick_o);
    end
  endtask

  task automatic test_move_up();
    do_reset();
    req_i = 4'b0100;
    adv(1);
    req_i = 4'b0000;
    checks++;
    if (pending_o !== 4'b0100 || moving_o !== 1'b0) begin
      failures++;
      $display("FAIL up_latch: pend=%b mov=%b want 0100 0", pending_o, moving_o);
    end
    goto_cyc(2);
    checks++;
    if (moving_o !== 1'b1 || dir_up_o !== 1'b1) begin
      failures++;
      $display("FAIL up_start: mov=%b dir=%b want 1 1", moving_o, dir_up_o);
    end
    goto_cyc(7);
    checks++;
    if (floor_o !== 2'd0) begin
      failures++;
      $display("FAIL up_floor0_hold: floor=%0d want 0", floor_o);
    end
    goto_cyc(8);
    checks++;
    if (floor_o !== 2'd1 || moving_o !== 1'b1) begin
      failures++;
      $display("FAIL up_floor1: floor=%0d mov=%b want 1 1", floor_o, moving_o);
    end
    goto_cyc(16);
    checks++;
    if (floor_o !== 2'd2 || door_open_o !== 1'b1 || moving_o !== 1'b0 || pending_o !== 4'b0000) begin
      failures++;
      $display("FAIL up_arrive2: floor=%0d door=%b mov=%b pend=%b want 2 1 0 0000",
               floor_o, door_open_o, moving_o, pending_o);
    end
    goto_cyc(27);
    checks++;
    if (door_open_o !== 1'b1) begin
      failures++;
      $display("FAIL up_dwell_end: door=%b want 1 at cyc 27", door_open_o);
    end
    goto_cyc(28);
    checks++;
    if (door_open_o !== 1'b0 || moving_o !== 1'b0 || floor_o !== 2'd2 || pending_o !== 4'b0000) begin
      failures++;
      $display("FAIL up_idle: door=%b mov=%b floor=%0d pend=%b want 0 0 2 0000",
               door_open_o, moving_o, floor_o, pending_o);
    end
  endtask

  task automatic test_door_here();
    do_reset();
    req_i = 4'b0001;
    adv(1);
    req_i = 4'b0000;
    checks++;
    if (door_open_o !== 1'b0 || pending_o !== 4'b0001) begin
      failures++;
      $display("FAIL here_latch: door=%b pend=%b want 0 0001", door_open_o, pending_o);
    end
    goto_cyc(2);
    checks++;
    if (door_open_o !== 1'b1 || floor_o !== 2'd0 || pending_o !== 4'b0000) begin
      failures++;
      $display("FAIL here_open: door=%b floor=%0d pend=%b want 1 0 0000", door_open_o, floor_o, pending_o);
    end
    for (int c = 3; c <= 11; c++) begin
      goto_cyc(c);
      checks++;
      if (door_open_o !== 1'b1 || pending_o[0] !== 1'b0 || floor_o !== 2'd0) begin
        failures++;
        $display("FAIL here_dwell: cyc=%0d door=%b pend0=%b floor=%0d want 1 0 0",
                 c, door_open_o, pending_o[0], floor_o);
      end
    end
    goto_cyc(12);
    checks++;
    if (door_open_o !== 1'b0 || moving_o !== 1'b0) begin
      failures++;
      $display("FAIL here_close: door=%b mov=%b want 0 0", door_open_o, moving_o);
    end
  endtask

  task automatic test_scan_reversal();
    do_reset();
    req_i = 4'b1000;
    adv(1);
    req_i = 4'b0000;
    goto_cyc(8);
    checks++;
    if (floor_o !== 2'd1 || moving_o !== 1'b1) begin
      failures++;
      $display("FAIL scan_at1: floor=%0d mov=%b want 1 1", floor_o, moving_o);
    end
    req_i = 4'b0001;
    adv(1);
    req_i = 4'b0000;
    checks++;
    if (pending_o !== 4'b1001) begin
      failures++;
      $display("FAIL scan_latch: pend=%b want 1001", pending_o);
    end
    goto_cyc(16);
    checks++;
    if (floor_o !== 2'd2 || moving_o !== 1'b1 || door_open_o !== 1'b0) begin
      failures++;
      $display("FAIL scan_pass2: floor=%0d mov=%b door=%b want 2 1 0", floor_o, moving_o, door_open_o);
    end
    goto_cyc(24);
    checks++;
    if (floor_o !== 2'd3 || door_open_o !== 1'b1 || dir_up_o !== 1'b1 || pending_o !== 4'b0001) begin
      failures++;
      $display("FAIL scan_open3: floor=%0d door=%b dir=%b pend=%b want 3 1 1 0001",
               floor_o, door_open_o, dir_up_o, pending_o);
    end
    goto_cyc(36);
    checks++;
    if (door_open_o !== 1'b0 || moving_o !== 1'b0) begin
      failures++;
      $display("FAIL scan_idle3: door=%b mov=%b want 0 0", door_open_o, moving_o);
    end
    goto_cyc(37);
    checks++;
    if (moving_o !== 1'b1 || dir_up_o !== 1'b0) begin
      failures++;
      $display("FAIL scan_reverse: mov=%b dir=%b want 1 0", moving_o, dir_up_o);
    end
    goto_cyc(59);
    checks++;
    if (floor_o !== 2'd1 || door_open_o !== 1'b0) begin
      failures++;
      $display("FAIL scan_pre0: floor=%0d door=%b want 1 0", floor_o, door_open_o);
    end
    goto_cyc(60);
    checks++;
    if (floor_o !== 2'd0 || door_open_o !== 1'b1 || dir_up_o !== 1'b0 || pending_o !== 4'b0000) begin
      failures++;
      $display("FAIL scan_open0: floor=%0d door=%b dir=%b pend=%b want 0 1 0 0000",
               floor_o, door_open_o, dir_up_o, pending_o);
    end
  endtask

  task automatic test_dwell_restart();
    do_reset();
    req_i = 4'b0100;
    adv(1);
    req_i = 4'b0000;
    goto_cyc(24);
    checks++;
    if (floor_o !== 2'd2 || door_open_o !== 1'b1) begin
      failures++;
      $display("FAIL restart_pre: floor=%0d door=%b want 2 1", floor_o, door_open_o);
    end
    req_i = 4'b0100;
    adv(1);
    req_i = 4'b0000;
    checks++;
    if (pending_o !== 4'b0000 || door_open_o !== 1'b1) begin
      failures++;
      $display("FAIL restart_absorb: pend=%b door=%b want 0000 1", pending_o, door_open_o);
    end
    goto_cyc(28);
    checks++;
    if (door_open_o !== 1'b1) begin
      failures++;
      $display("FAIL restart_held: door=%b want 1 at cyc 28", door_open_o);
    end
    goto_cyc(35);
    checks++;
    if (door_open_o !== 1'b1 || pending_o !== 4'b0000) begin
      failures++;
      $display("FAIL restart_last: door=%b pend=%b want 1 0000", door_open_o, pending_o);
    end
    goto_cyc(36);
    checks++;
    if (door_open_o !== 1'b0 || moving_o !== 1'b0) begin
      failures++;
      $display("FAIL restart_close: door=%b mov=%b want 0 0", door_open_o, moving_o);
    end
  endtask

  task automatic test_reset_mid_move();
    do_reset();
    req_i = 4'b1000;
    adv(1);
    req_i = 4'b0000;
    goto_cyc(9);
    checks++;
    if (floor_o !== 2'd1 || moving_o !== 1'b1 || pending_o !== 4'b1000) begin
      failures++;
      $display("FAIL midrst_pre: floor=%0d mov=%b pend=%b want 1 1 1000", floor_o, moving_o, pending_o);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    checks++;
    if ({floor_o, dir_up_o, moving_o, door_open_o, pending_o, tick_o} !== {2'd0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0}) begin
      failures++;
      $display("FAIL midrst_values: floor=%0d dir=%b mov=%b door=%b pend=%b tick=%b want 0 1 0 0 0000 0",
               floor_o, dir_up_o, moving_o, door_open_o, pending_o, tick_o);
    end
    goto_cyc(2);
    checks++;
    if (tick_o !== 1'b0) begin
      failures++;
      $display("FAIL midrst_tick_early: tick_o=%b want 0", tick_o);
    end
    goto_cyc(3);
    checks++;
    if (tick_o !== 1'b1 || moving_o !== 1'b0 || pending_o !== 4'b0000) begin
      failures++;
      $display("FAIL midrst_tick_phase: tick=%b mov=%b pend=%b want 1 0 0000", tick_o, moving_o, pending_o);
    end
  endtask

  task automatic test_tie_up();
    do_reset();
    req_i = 4'b0100;
    adv(1);
    req_i = 4'b0000;
    goto_cyc(28);
    checks++;
    if (floor_o !== 2'd2 || door_open_o !== 1'b0 || moving_o !== 1'b0 || dir_up_o !== 1'b1) begin
      failures++;
      $display("FAIL tie_pre: floor=%0d door=%b mov=%b dir=%b want 2 0 0 1",
               floor_o, door_open_o, moving_o, dir_up_o);
    end
    req_i = 4'b1001;
    adv(1);
    req_i = 4'b0000;
    checks++;
    if (pending_o !== 4'b1001 || moving_o !== 1'b0) begin
      failures++;
      $display("FAIL tie_latch: pend=%b mov=%b want 1001 0", pending_o, moving_o);
    end
    goto_cyc(30);
    checks++;
    if (moving_o !== 1'b1 || dir_up_o !== 1'b1) begin
      failures++;
      $display("FAIL tie_goes_up: mov=%b dir=%b want 1 1", moving_o, dir_up_o);
    end
    goto_cyc(36);
    checks++;
    if (floor_o !== 2'd3 || door_open_o !== 1'b1 || pending_o !== 4'b0001) begin
      failures++;
      $display("FAIL tie_open3: floor=%0d door=%b pend=%b want 3 1 0001", floor_o, door_open_o, pending_o);
    end
    goto_cyc(49);
    checks++;
    if (moving_o !== 1'b1 || dir_up_o !== 1'b0) begin
      failures++;
      $display("FAIL tie_down: mov=%b dir=%b want 1 0", moving_o, dir_up_o);
    end
    goto_cyc(56);
    checks++;
    if (floor_o !== 2'd2 || moving_o !== 1'b1) begin
      failures++;
      $display("FAIL tie_pass2: floor=%0d mov=%b want 2 1", floor_o, moving_o);
    end
    goto_cyc(72);
    checks++;
    if (floor_o !== 2'd0 || door_open_o !== 1'b1 || pending_o !== 4'b0000) begin
      failures++;
      $display("FAIL tie_open0: floor=%0d door=%b pend=%b want 0 1 0000", floor_o, door_open_o, pending_o);
    end
  endtask

  initial begin
    rst   = 1'b1;
    req_i = 4'b0000;
    test_reset();
    test_move_up();
    test_door_here();
    test_scan_reversal();
    test_dwell_restart();
    test_reset_mid_move();
    test_tie_up();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
